// File: rtl/boss_sprite_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : boss_sprite_controller
// Description : Boss sprite sequencer for the Space Invaders VGA datapath.
//               Drives the sprite top-left position, gates visibility for
//               hit/death blinking, tracks hit points and issues periodic
//               fire requests. All motion advances once per frame tick.
// Revision    : 1.0 - initial release
// ============================================================================
module boss_sprite_controller #(
    parameter int OBJECT_WIDTH = 32,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 639,
    parameter int START_X      = 304,
    parameter int START_Y      = 0,
    parameter int PATROL_Y     = 48,
    parameter int SPEED        = 2,
    parameter int HP_INIT      = 8,
    parameter int HIT_FRAMES   = 16,
    parameter int DEATH_FRAMES = 64,
    parameter int FIRE_PERIOD  = 45
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        bossStart,
    input  logic        hitPulse,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        bossVisible,
    output logic        bossActive,
    output logic        fireRequest,
    output logic [10:0] fireX,
    output logic [10:0] fireY,
    output logic [3:0]  hpLeft,
    output logic        bossDefeated
);

    // State encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ENTER  = 3'd1;
    localparam logic [2:0] c_ST_PATROL = 3'd2;
    localparam logic [2:0] c_ST_HIT    = 3'd3;
    localparam logic [2:0] c_ST_DYING  = 3'd4;
    localparam logic [2:0] c_ST_DEAD   = 3'd5;

    // Geometry and timing constants, pre-sized to the datapath widths
    localparam logic [10:0] c_X_RIGHT    = 11'(X_MAX - OBJECT_WIDTH + 1);
    localparam logic [10:0] c_X_MIN      = 11'(X_MIN);
    localparam logic [10:0] c_SPEED      = 11'(SPEED);
    localparam logic [10:0] c_START_X    = 11'(START_X);
    localparam logic [10:0] c_START_Y    = 11'(START_Y);
    localparam logic [10:0] c_PATROL_Y   = 11'(PATROL_Y);
    localparam logic [10:0] c_HALF_W     = 11'(OBJECT_WIDTH / 2);
    localparam logic [10:0] c_FIRE_Y_OFS = 11'd32;
    localparam logic [3:0]  c_HP_INIT    = 4'(HP_INIT);
    localparam logic [7:0]  c_HIT_LAST   = 8'(HIT_FRAMES - 1);
    localparam logic [7:0]  c_DEATH_LAST = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0]  c_FIRE_LAST  = 8'(FIRE_PERIOD - 1);

    // Registered state
    logic [2:0]  r_state;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_dir_left;
    logic [3:0]  r_hp;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  r_fire_cnt;
    logic        r_hit_d;
    logic        r_visible;
    logic        r_active;
    logic        r_fire_req;
    logic [10:0] r_fire_x;
    logic [10:0] r_fire_y;
    logic        r_defeated;

    // Next-value wires
    logic [2:0]  w_state_next;
    logic [10:0] w_x_next;
    logic [10:0] w_y_next;
    logic        w_dir_left_next;
    logic [3:0]  w_hp_next;
    logic [7:0]  w_frame_cnt_next;
    logic [7:0]  w_fire_cnt_next;
    logic        w_fire_due;
    logic        w_fire_req_next;
    logic [10:0] w_fire_x_next;
    logic [10:0] w_fire_y_next;
    logic        w_visible_next;
    logic        w_active_next;
    logic        w_defeated_next;
    logic        w_hit_edge;
    logic        w_tick;

    // A long collision pulse counts once: only its first clk is a hit
    assign w_hit_edge = hitPulse & ~r_hit_d;
    assign w_tick     = startOfFrame;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DEAD: begin
                if (bossStart) begin
                    w_state_next = c_ST_ENTER;
                end
            end
            c_ST_ENTER: begin
                if (w_tick && (r_y + 11'd1 == c_PATROL_Y)) begin
                    w_state_next = c_ST_PATROL;
                end
            end
            c_ST_PATROL: begin
                if (w_hit_edge) begin
                    w_state_next = (r_hp == 4'd1) ? c_ST_DYING : c_ST_HIT;
                end
            end
            c_ST_HIT: begin
                if (w_tick && (r_frame_cnt == c_HIT_LAST)) begin
                    w_state_next = c_ST_PATROL;
                end
            end
            c_ST_DYING: begin
                if (w_tick && (r_frame_cnt == c_DEATH_LAST)) begin
                    w_state_next = c_ST_DEAD;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        w_x_next         = r_x;
        w_y_next         = r_y;
        w_dir_left_next  = r_dir_left;
        w_hp_next        = r_hp;
        w_frame_cnt_next = r_frame_cnt;
        w_fire_cnt_next  = r_fire_cnt;
        w_fire_due       = 1'b0;
        w_fire_x_next    = r_fire_x;
        w_fire_y_next    = r_fire_y;
        w_defeated_next  = 1'b0;

        case (r_state)
            c_ST_IDLE, c_ST_DEAD: begin
                if (bossStart) begin
                    w_x_next         = c_START_X;
                    w_y_next         = c_START_Y;
                    w_dir_left_next  = 1'b0;
                    w_hp_next        = c_HP_INIT;
                    w_frame_cnt_next = 8'd0;
                    w_fire_cnt_next  = 8'd0;
                end
            end
            c_ST_ENTER: begin
                if (w_tick) begin
                    if (r_y + 11'd1 == c_PATROL_Y) begin
                        w_y_next        = c_PATROL_Y;
                        w_fire_cnt_next = 8'd0;
                    end else begin
                        w_y_next = r_y + 11'd1;
                    end
                end
            end
            c_ST_PATROL, c_ST_HIT: begin
                if (w_tick) begin
                    // Clamp to the bound and reverse on the same tick
                    if (!r_dir_left) begin
                        if (r_x + c_SPEED >= c_X_RIGHT) begin
                            w_x_next        = c_X_RIGHT;
                            w_dir_left_next = 1'b1;
                        end else begin
                            w_x_next = r_x + c_SPEED;
                        end
                    end else begin
                        if (r_x <= c_X_MIN + c_SPEED) begin
                            w_x_next        = c_X_MIN;
                            w_dir_left_next = 1'b0;
                        end else begin
                            w_x_next = r_x - c_SPEED;
                        end
                    end
                    if (r_fire_cnt == c_FIRE_LAST) begin
                        w_fire_cnt_next = 8'd0;
                        w_fire_due      = 1'b1;
                    end else begin
                        w_fire_cnt_next = r_fire_cnt + 8'd1;
                    end
                    if (r_state == c_ST_HIT) begin
                        w_frame_cnt_next = (r_frame_cnt == c_HIT_LAST) ? 8'd0 : r_frame_cnt + 8'd1;
                    end
                end
                // A hit on a tick clk still lets the movement step above apply
                if ((r_state == c_ST_PATROL) && w_hit_edge) begin
                    w_hp_next        = r_hp - 4'd1;
                    w_frame_cnt_next = 8'd0;
                end
            end
            c_ST_DYING: begin
                if (w_tick) begin
                    if (r_frame_cnt == c_DEATH_LAST) begin
                        w_frame_cnt_next = 8'd0;
                        w_defeated_next  = 1'b1;
                    end else begin
                        w_frame_cnt_next = r_frame_cnt + 8'd1;
                    end
                end
            end
            default: ;
        endcase

        // A fire falling on a clk that leaves PATROL/HIT is dropped
        w_fire_req_next = w_fire_due &&
                          ((w_state_next == c_ST_PATROL) || (w_state_next == c_ST_HIT));
        if (w_fire_req_next) begin
            w_fire_x_next = w_x_next + c_HALF_W;
            w_fire_y_next = w_y_next + c_FIRE_Y_OFS;
        end

        // Visibility follows the state and blink counter the sprite will show
        case (w_state_next)
            c_ST_ENTER, c_ST_PATROL: w_visible_next = 1'b1;
            c_ST_HIT:                w_visible_next = ~w_frame_cnt_next[2];
            c_ST_DYING:              w_visible_next = ~w_frame_cnt_next[1];
            default:                 w_visible_next = 1'b0;
        endcase

        w_active_next = (w_state_next == c_ST_ENTER)  || (w_state_next == c_ST_PATROL) ||
                        (w_state_next == c_ST_HIT)    || (w_state_next == c_ST_DYING);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x         <= c_START_X;
            r_y         <= c_START_Y;
            r_dir_left  <= 1'b0;
            r_hp        <= 4'd0;
            r_frame_cnt <= 8'd0;
            r_fire_cnt  <= 8'd0;
            r_hit_d     <= 1'b0;
            r_visible   <= 1'b0;
            r_active    <= 1'b0;
            r_fire_req  <= 1'b0;
            r_fire_x    <= 11'd0;
            r_fire_y    <= 11'd0;
            r_defeated  <= 1'b0;
        end else begin
            r_x         <= w_x_next;
            r_y         <= w_y_next;
            r_dir_left  <= w_dir_left_next;
            r_hp        <= w_hp_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_fire_cnt  <= w_fire_cnt_next;
            r_hit_d     <= hitPulse;
            r_visible   <= w_visible_next;
            r_active    <= w_active_next;
            r_fire_req  <= w_fire_req_next;
            r_fire_x    <= w_fire_x_next;
            r_fire_y    <= w_fire_y_next;
            r_defeated  <= w_defeated_next;
        end
    end

    assign topLeftX     = r_x;
    assign topLeftY     = r_y;
    assign bossVisible  = r_visible;
    assign bossActive   = r_active;
    assign fireRequest  = r_fire_req;
    assign fireX        = r_fire_x;
    assign fireY        = r_fire_y;
    assign hpLeft       = r_hp;
    assign bossDefeated = r_defeated;

endmodule
`default_nettype wire

// File: tb/tb_boss_sprite_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_boss_sprite_controller
// Description : Scoreboard bench for boss_sprite_controller. The driver pushes
//               the expected per-frame snapshot, fire and defeat events; a
//               monitor pops and compares them as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boss_sprite_controller;

    localparam int ST_IDLE = 0, ST_ENTER = 1, ST_PATROL = 2, ST_HIT = 3, ST_DYING = 4, ST_DEAD = 5;

    logic        clk = 1'b0;
    logic        reset, startOfFrame, bossStart, hitPulse;
    logic [10:0] topLeftX, topLeftY, fireX, fireY;
    logic        bossVisible, bossActive, fireRequest, bossDefeated;
    logic [3:0]  hpLeft;

    always #5 clk = ~clk;

    boss_sprite_controller dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .bossStart(bossStart),
        .hitPulse(hitPulse), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .bossVisible(bossVisible), .bossActive(bossActive), .fireRequest(fireRequest),
        .fireX(fireX), .fireY(fireY), .hpLeft(hpLeft), .bossDefeated(bossDefeated)
    );

    typedef struct { int x; int y; bit vis; bit act; int hp; int tick; } snap_t;
    typedef struct { int tick; int fx; int fy; } fire_t;

    snap_t snap_q[$];
    fire_t fire_q[$];
    int    defeat_q[$];

    int  checks = 0;
    int  failures = 0;
    int  drv_ticks = 0;
    bit  done = 0;

    // Expected-behaviour state, advanced once per driven clk
    int m_state, m_x, m_y, m_hp, m_fc, m_fcnt;
    bit m_left, m_prev_hit;

    task automatic model_step(input bit sof, input bit hit, input bit start, input bit rst);
        bit    hit_edge;
        bit    fire_ev;
        int    nstate;
        snap_t s;
        fire_t f;
        hit_edge = hit && !m_prev_hit;
        m_prev_hit = hit;
        fire_ev = 0;
        if (rst) begin
            m_state = ST_IDLE; m_x = 304; m_y = 0; m_hp = 0; m_fc = 0; m_fcnt = 0;
            m_left = 0; m_prev_hit = 0;
        end else begin
            nstate = m_state;
            case (m_state)
                ST_IDLE, ST_DEAD: if (start) begin
                    nstate = ST_ENTER; m_x = 304; m_y = 0; m_hp = 8; m_left = 0; m_fc = 0; m_fcnt = 0;
                end
                ST_ENTER: if (sof) begin
                    if (m_y + 1 == 48) begin m_y = 48; nstate = ST_PATROL; m_fcnt = 0; end
                    else m_y = m_y + 1;
                end
                ST_PATROL, ST_HIT: begin
                    if (sof) begin
                        if (!m_left) begin
                            if (m_x + 2 >= 608) begin m_x = 608; m_left = 1; end
                            else m_x = m_x + 2;
                        end else begin
                            if (m_x <= 2) begin m_x = 0; m_left = 0; end
                            else m_x = m_x - 2;
                        end
                        if (m_fcnt == 44) begin m_fcnt = 0; fire_ev = 1; end
                        else m_fcnt = m_fcnt + 1;
                        if (m_state == ST_HIT) begin
                            if (m_fc == 15) nstate = ST_PATROL;
                            else m_fc = m_fc + 1;
                        end
                    end
                    if (m_state == ST_PATROL && hit_edge) begin
                        m_fc = 0;
                        nstate = (m_hp == 1) ? ST_DYING : ST_HIT;
                        m_hp = m_hp - 1;
                    end
                end
                ST_DYING: if (sof) begin
                    if (m_fc == 63) begin nstate = ST_DEAD; defeat_q.push_back(drv_ticks); end
                    else m_fc = m_fc + 1;
                end
                default: ;
            endcase
            m_state = nstate;
            if (fire_ev && (nstate == ST_PATROL || nstate == ST_HIT)) begin
                f.tick = drv_ticks; f.fx = m_x + 16; f.fy = m_y + 32;
                fire_q.push_back(f);
            end
        end
        if (sof) begin
            s.x = m_x; s.y = m_y; s.hp = m_hp; s.tick = drv_ticks;
            case (m_state)
                ST_ENTER, ST_PATROL: s.vis = 1;
                ST_HIT:              s.vis = ((m_fc & 4) == 0);
                ST_DYING:            s.vis = ((m_fc & 2) == 0);
                default:             s.vis = 0;
            endcase
            s.act = (m_state == ST_ENTER || m_state == ST_PATROL || m_state == ST_HIT || m_state == ST_DYING);
            snap_q.push_back(s);
        end
    endtask

    task automatic drive(input bit sof, input bit hit, input bit start, input bit rst);
        @(negedge clk);
        startOfFrame = sof; hitPulse = hit; bossStart = start; reset = rst;
        if (sof) drv_ticks = drv_ticks + 1;
        model_step(sof, hit, start, rst);
    endtask

    task automatic tick(input bit hit);
        drive(1, hit, 0, 0);
        repeat (3) drive(0, 0, 0, 0);
    endtask

    // Monitor: compares every DUT presentation against the scoreboard
    logic tick_seen = 1'b0;
    int   mon_ticks = 0;
    always @(posedge clk) tick_seen <= startOfFrame;

    always @(negedge clk) begin
        snap_t s;
        fire_t f;
        int    d;
        int    idx;
        if (tick_seen) mon_ticks = mon_ticks + 1;
        idx = tick_seen ? mon_ticks : -1;
        if (tick_seen) begin
            checks = checks + 1;
            if (snap_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL snapshot tick=%0d: no expected entry queued", mon_ticks);
            end else begin
                s = snap_q.pop_front();
                if (int'(topLeftX) != s.x || int'(topLeftY) != s.y || bossVisible != s.vis ||
                    bossActive != s.act || int'(hpLeft) != s.hp) begin
                    failures = failures + 1;
                    $display("FAIL snapshot tick=%0d: got x=%0d y=%0d vis=%0b act=%0b hp=%0d, want x=%0d y=%0d vis=%0b act=%0b hp=%0d",
                             s.tick, topLeftX, topLeftY, bossVisible, bossActive, hpLeft,
                             s.x, s.y, s.vis, s.act, s.hp);
                end
            end
        end
        if (fireRequest) begin
            checks = checks + 1;
            if (fire_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL fire_unexpected: got fireRequest=1 at tick index %0d, want none", idx);
            end else begin
                f = fire_q.pop_front();
                if (idx != f.tick || int'(fireX) != f.fx || int'(fireY) != f.fy) begin
                    failures = failures + 1;
                    $display("FAIL fire: got tick=%0d fireX=%0d fireY=%0d, want tick=%0d fireX=%0d fireY=%0d",
                             idx, fireX, fireY, f.tick, f.fx, f.fy);
                end
            end
        end
        if (bossDefeated) begin
            checks = checks + 1;
            if (defeat_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL defeated_unexpected: got bossDefeated=1 at tick index %0d, want none", idx);
            end else begin
                d = defeat_q.pop_front();
                if (idx != d) begin
                    failures = failures + 1;
                    $display("FAIL defeated: got pulse at tick %0d, want tick %0d", idx, d);
                end
            end
        end
        if (done) begin
            checks = checks + 1;
            if (snap_q.size() != 0 || fire_q.size() != 0 || defeat_q.size() != 0) begin
                failures = failures + 1;
                $display("FAIL leftover: got snap=%0d fire=%0d defeat=%0d pending, want 0 0 0",
                         snap_q.size(), fire_q.size(), defeat_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // Stimulus
    initial begin
        int guard;
        reset = 1; startOfFrame = 0; bossStart = 0; hitPulse = 0;
        repeat (3) drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        tick(0);                              // idle after reset
        drive(0, 0, 1, 0);                    // start
        repeat (48) tick(0);                  // entry descent to Y=48
        repeat (148) tick(0);                 // patrol right to X=600, three fires
        repeat (5) tick(0);                   // 602,604,606,608 clamp, 606
        repeat (5) drive(0, 1, 0, 0);         // long collision pulse: one hit
        repeat (3) tick(0);
        repeat (2) drive(0, 1, 0, 0);         // ignored while HIT
        repeat (14) tick(0);                  // blink ends, back to PATROL
        guard = 0;
        while (!(m_x == 2 && m_left) && guard < 1000) begin
            tick(0);
            guard++;
        end
        repeat (2) tick(0);                   // 0 clamp, then 2
        for (int i = 0; i < 6; i++) begin
            if (i == 2) tick(1);              // hit on a tick clk
            else repeat (3) drive(0, 1, 0, 0);
            repeat (18) tick(0);
        end
        repeat (2) drive(0, 1, 0, 0);         // eighth hit -> DYING
        repeat (66) tick(0);                  // death blink, DEAD
        drive(0, 0, 1, 0);                    // restart from DEAD
        repeat (50) tick(0);
        tick(1);                              // hit + tick -> HIT
        repeat (3) tick(0);
        drive(1, 0, 0, 1);                    // reset mid-HIT on a tick
        drive(0, 0, 0, 0);
        tick(0);
        repeat (3) drive(0, 0, 0, 0);
        done = 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
